// File: rtl/uart_transmitter.sv
// UART transmitter: valid/ready byte FIFO feeding an 8N1 serialiser at a fixed CLKS_PER_BIT rate.
// Define UART_TX_PARITY_EN to add an even-parity bit between data bit 7 and stop (8E1).
module uart_transmitter #(
   parameter int CLKS_PER_BIT = 87,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [7:0]                       tx_data,
   input  logic                             tx_valid,
   output logic                             tx_ready,
   output logic                             output_serial,
   output logic                             busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
      , S_PARITY = 3'd4
`endif
   } state_t;

   state_t             state_q, state_d;
   logic [BAUD_W-1:0]  baud_q, baud_d, baud_next;
   logic               baud_done;
   logic [2:0]         bit_idx_q, bit_idx_d;
   logic [7:0]         shift_q, shift_d;
   logic               serial_q, serial_d;
`ifdef UART_TX_PARITY_EN
   logic               parity_q, parity_d;
`endif

   logic [7:0]         mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               push;
   logic               pop;
   logic [7:0]         rd_data;

   // Ready comes from the registered count only, so a full FIFO refuses a push even on a pop cycle.
   assign tx_ready      = (count_q != CNT_FULL);
   assign push          = tx_valid && tx_ready;
   assign rd_data       = mem_q[rd_ptr_q];
   assign fifo_count    = count_q;
   assign output_serial = serial_q;
   assign busy          = (state_q != S_IDLE) || (count_q != '0);

   assign baud_done = (baud_q == BAUD_LAST);
   assign baud_next = baud_done ? '0 : baud_q + BAUD_W'(1);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= tx_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         serial_q  <= 1'b1;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         serial_q  <= serial_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_done) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_done && (bit_idx_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
               state_d = S_PARITY;
`else
               state_d = S_STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_done) begin
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (baud_done) begin
               state_d = (count_q != '0) ? S_START : S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Line level is chosen from the next state so the flop presents each bit on its first cycle.
   always_comb begin
      pop       = 1'b0;
      baud_d    = '0;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      serial_d  = 1'b1;
      case (state_q)
         S_IDLE: begin
            pop = (count_q != '0);
         end
         S_START: begin
            baud_d = baud_next;
            if (baud_done) begin
               bit_idx_d = '0;
            end
         end
         S_DATA: begin
            baud_d = baud_next;
            if (baud_done) begin
               bit_idx_d = bit_idx_q + 3'd1;
               shift_d   = shift_q >> 1;
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            baud_d = baud_next;
         end
`endif
         S_STOP: begin
            baud_d = baud_next;
            pop    = baud_done && (count_q != '0);
         end
         default: begin
            baud_d = '0;
         end
      endcase

      if (pop) begin
         shift_d = rd_data;
      end
`ifdef UART_TX_PARITY_EN
      parity_d = pop ? ^rd_data : parity_q;
`endif

      case (state_d)
         S_START:  serial_d = 1'b0;
         S_DATA:   serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: serial_d = parity_d;
`endif
         default:  serial_d = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at CLKS_PER_BIT=4, FIFO_DEPTH=8; honours UART_TX_PARITY_EN.
module tb_uart_transmitter;

   localparam int C = 4;
   localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic       clk;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       output_serial;
   logic       busy;
   logic [3:0] fifo_count;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [7:0] pend[$];
   logic [7:0] d[20];

   uart_transmitter #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .output_serial (output_serial),
      .busy          (busy),
      .fifo_count    (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock; the producer queue drives tx_valid/tx_data and retires a byte on each handshake.
   task automatic tick();
      logic acc;
      acc = tx_valid && tx_ready;
      @(posedge clk);
      #1;
      if (acc && pend.size() > 0) void'(pend.pop_front());
      if (pend.size() > 0) begin
         tx_valid = 1'b1;
         tx_data  = pend[0];
      end else begin
         tx_valid = 1'b0;
      end
   endtask

   task automatic start_push(input logic [7:0] b);
      pend.push_back(b);
      tx_valid = 1'b1;
      tx_data  = pend[0];
   endtask

   // Called on the first sample of a start bit; returns on the first sample after the stop bit.
   // mode 1: probe full FIFO at sample 7; mode 2: probe count 3 and offer nb on the last sample.
   task automatic check_frame(input logic [7:0] b, input int mode, input logic [7:0] nb);
      logic [NB-1:0] bits;
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
      bits[9] = ^b;
`endif
      bits[NB-1] = 1'b1;
      for (int k = 0; k < NB; k++) begin
         for (int c = 0; c < C; c++) begin
            check($sformatf("frame_%02h_bit%0d_cyc%0d", b, k, c), 32'(output_serial), 32'(bits[k]));
            if (mode == 1 && (k * C + c) == 7) begin
               check("full_count", 32'(fifo_count), 32'd8);
               check("full_ready", 32'(tx_ready), 32'd0);
            end
            if (mode == 2 && k == NB - 1 && c == C - 1) begin
               check("simul_count_pre", 32'(fifo_count), 32'd3);
               start_push(nb);
            end
            tick();
         end
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_serial"}, 32'(output_serial), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_count"}, 32'(fifo_count), 32'd0);
      check({tag, "_ready"}, 32'(tx_ready), 32'd1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench timed out");
   end

   initial begin
      int bad;
      rst      = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;

      // Reset state and a quiet idle line
      repeat (3) tick();
      check_idle("reset");
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (output_serial !== 1'b1) bad++;
      end
      check("idle_line_low_cycles", 32'(bad), 32'd0);
      check_idle("idle100");

      // Single byte 0xA5
      start_push(8'hA5);
      tick();
      check("single_count_after_push", 32'(fifo_count), 32'd1);
      check("single_busy_after_push", 32'(busy), 32'd1);
      check("single_serial_before_pop", 32'(output_serial), 32'd1);
      tick();
      check("single_count_after_pop", 32'(fifo_count), 32'd0);
      check("single_busy_in_frame", 32'(busy), 32'd1);
      check_frame(8'hA5, 0, 8'h00);
      check_idle("single_end");

      // Burst of 11 bytes held on tx_valid, FIFO fills and refuses until space
      for (int i = 0; i < 11; i++) pend.push_back(8'(i));
      tx_valid = 1'b1;
      tx_data  = pend[0];
      tick();
      tick();
      for (int f = 0; f < 11; f++) begin
         check_frame(8'(f), (f == 0) ? 1 : 0, 8'h00);
         if (f == 0) begin
            check("burst_count_after_pop", 32'(fifo_count), 32'd7);
            check("burst_ready_reasserted", 32'(tx_ready), 32'd1);
         end
      end
      check("burst_all_accepted", 32'(pend.size()), 32'd0);
      check_idle("burst_end");

      // Push coinciding with pop at stop end, 20 bytes across pointer wrap
      for (int i = 0; i < 20; i++) d[i] = 8'(i * 37 + 5);
      for (int i = 0; i < 4; i++) pend.push_back(d[i]);
      tx_valid = 1'b1;
      tx_data  = pend[0];
      tick();
      tick();
      for (int f = 0; f < 20; f++) begin
         check_frame(d[f], (f < 16) ? 2 : 0, (f < 16) ? d[f+4] : 8'h00);
         if (f < 16) check($sformatf("simul_count_post_%0d", f), 32'(fifo_count), 32'd3);
      end
      check_idle("wrap_end");

      // Reset during data bit 3 of 0x3C with two bytes queued
      start_push(8'h3C);
      pend.push_back(8'h11);
      pend.push_back(8'h22);
      tick();
      tick();
      check("rst_test_start_bit", 32'(output_serial), 32'd0);
      repeat (17) tick();
      check("rst_test_bit3_level", 32'(output_serial), 32'd1);
      check("rst_test_queued", 32'(fifo_count), 32'd2);
      check("rst_test_busy", 32'(busy), 32'd1);
      #2 rst = 1'b0;
      #1;
      check_idle("rst_async");
      repeat (2) tick();
      check_idle("rst_held");
      rst = 1'b1;
      start_push(8'h81);
      tick();
      check("post_rst_count", 32'(fifo_count), 32'd1);
      tick();
      check_frame(8'h81, 0, 8'h00);
      check_idle("post_rst_end");

`ifdef UART_TX_PARITY_EN
      // Even parity: 0x07 carries 1, 0x03 carries 0, 44 cycles per frame
      start_push(8'h07);
      tick();
      tick();
      check_frame(8'h07, 0, 8'h00);
      check_idle("parity07_end");
      start_push(8'h03);
      tick();
      tick();
      check_frame(8'h03, 0, 8'h00);
      check_idle("parity03_end");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
